pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline flow controller for the in-order core, the successor to the fixed 5-stage flush/stall unit. It tracks misses on an arbitrary number of cache channels, each attached to a configurable pipeline stage. It generates per-register hold and flush vectors and arbitrates redirect requests from multiple stages by age. Accepted redirects are held toward fetch behind a valid/ack handshake, and saturating stall-cycle counters are kept per channel.

---
 rtl/pipe_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//
// Pipeline flow controller for the in-order core. It tracks cache misses on
// NUM_CH channels, each attached to one pipeline stage, and turns them into
// per-register hold/flush vectors. It also arbitrates redirect requests from
// NUM_RD stages by instruction age and holds the accepted target toward fetch
// behind a valid/ack handshake. Each channel has a saturating counter of the
// cycles it spent stalling.
//
// Stage numbering: stage 0 is fetch; register R_k (k >= 1) feeds stage k.
//
// Ports
//   clk              clock
//   rst_n            asynchronous active-low reset
//   ch_req_i         [NUM_CH]         channel issues an access this cycle
//   ch_hit_i         [NUM_CH]         hit result, same cycle as ch_req_i
//   ch_fill_ready_i  [NUM_CH]         refill-ready level; only its rising edge matters
//   rd_valid_i       [NUM_RD]         redirect request per source
//   rd_pc_i          [NUM_RD*ADDR_W]  redirect target per source
//   redirect_ack_i                    fetch consumed the pending redirect
//   hold_o           [STAGES]         bit 0 holds the PC, bit k holds R_k
//   flush_o          [STAGES]         bit 0 kills fetch output, bit k bubbles R_k
//   redirect_valid_o                  a pending redirect is present
//   redirect_pc_o    [ADDR_W]         pending redirect target
//   stall_cnt_o      [NUM_CH*CNT_W]   stall cycles per channel (saturating)
//
// hold_o and flush_o may both be set on the same register; the consumer
// treats flush as dominant, so that register clears to a bubble.

module pipe_hazard_ctrl #(
    parameter int                  STAGES   = 5,
    parameter int                  NUM_CH   = 2,
    parameter logic [NUM_CH*4-1:0] CH_STAGE = {4'd3, 4'd0},
    parameter int                  NUM_RD   = 2,
    parameter logic [NUM_RD*4-1:0] RD_STAGE = {4'd2, 4'd1},
    parameter int                  ADDR_W   = 32,
    parameter int                  CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_req_i,
    input  logic [NUM_CH-1:0]        ch_hit_i,
    input  logic [NUM_CH-1:0]        ch_fill_ready_i,
    input  logic [NUM_RD-1:0]        rd_valid_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_pc_i,
    input  logic                     redirect_ack_i,
    output logic [STAGES-1:0]        hold_o,
    output logic [STAGES-1:0]        flush_o,
    output logic                     redirect_valid_o,
    output logic [ADDR_W-1:0]        redirect_pc_o,
    output logic [NUM_CH*CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } ch_state_e;

    // ------------------------------------------------------------------
    // Per-channel miss FSM
    // ------------------------------------------------------------------
    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [NUM_CH-1:0] fill_q;
    logic [NUM_CH-1:0] fill_rise;
    logic [NUM_CH-1:0] miss_req;
    logic [NUM_CH-1:0] ch_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
            end
            fill_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples the pre-edge values regardless of statement order.
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
            end
            fill_q <= ch_fill_ready_i;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        fill_rise = '0;
        miss_req  = '0;
        ch_stall  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]   = state_q[c];
            fill_rise[c] = ch_fill_ready_i[c] & ~fill_q[c];
            miss_req[c]  = ch_req_i[c] & ~ch_hit_i[c];
            case (state_q[c])
                ST_IDLE: begin
                    // A fill edge seen while idle is ignored.
                    if (miss_req[c]) begin
                        state_d[c]  = ST_MISS;
                        ch_stall[c] = 1'b1;
                    end
                end
                ST_MISS: begin
                    // The fill edge releases the stall in the same cycle. A
                    // new miss coinciding with the edge keeps the FSM in MISS.
                    ch_stall[c] = ~fill_rise[c];
                    if (fill_rise[c] && !miss_req[c]) begin
                        state_d[c] = ST_IDLE;
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pending redirect register (declared here, used by arbitration)
    // ------------------------------------------------------------------
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_pc;

    // ------------------------------------------------------------------
    // Hold / bubble generation and redirect arbitration
    // ------------------------------------------------------------------
    logic [STAGES-1:0] hold_vec;
    logic [STAGES-1:0] flush_vec;
    logic              any_stall;
    int                cmax;
    logic              accept;
    int                win_stage;
    logic [ADDR_W-1:0] win_pc;

    always_comb begin
        any_stall = 1'b0;
        cmax      = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_stall[c]) begin
                any_stall = 1'b1;
                if (32'(CH_STAGE[c*4 +: 4]) > cmax) begin
                    cmax = 32'(CH_STAGE[c*4 +: 4]);
                end
            end
        end

        // Everything up to the deepest stalled stage freezes; the register
        // just below it takes a bubble, and deeper stages keep draining.
        hold_vec  = '0;
        flush_vec = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (any_stall && (k <= cmax)) begin
                hold_vec[k] = 1'b1;
            end
            if (any_stall && (k == cmax + 1)) begin
                flush_vec[k] = 1'b1;
            end
        end

        // A pending redirect keeps the PC frozen and kills fetch output so
        // no wrong-path instruction enters R_1 before fetch acknowledges.
        hold_vec[0]  = hold_vec[0]  | pend_valid;
        flush_vec[0] = flush_vec[0] | pend_valid;

        // Age arbitration: the deepest eligible source is the oldest
        // instruction. Strict '>' keeps the lower index on a stage tie.
        accept    = 1'b0;
        win_stage = 0;
        win_pc    = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            int   rs;
            logic held;
            rs   = 32'(RD_STAGE[r*4 +: 4]);
            held = 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                if (k == rs) begin
                    held = hold_vec[k];
                end
            end
            if (rd_valid_i[r] && !held && (!accept || (rs > win_stage))) begin
                accept    = 1'b1;
                win_stage = rs;
                win_pc    = rd_pc_i[r*ADDR_W +: ADDR_W];
            end
        end

        // An accepted redirect squashes every younger register, including
        // the one holding the redirecting instruction's successors.
        for (int k = 0; k < STAGES; k++) begin
            if (accept && (k <= win_stage)) begin
                flush_vec[k] = 1'b1;
            end
        end
    end

    // Outputs are forced quiet while reset is asserted, independent of inputs.
    assign hold_o  = rst_n ? hold_vec  : '0;
    assign flush_o = rst_n ? flush_vec : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else if (accept) begin
            // A new accept wins over a same-cycle ack and overwrites the target.
            pend_valid <= 1'b1;
            pend_pc    <= win_pc;
        end else if (redirect_ack_i) begin
            pend_valid <= 1'b0;
        end
    end

    assign redirect_valid_o = pend_valid;
    assign redirect_pc_o    = pend_pc;

    // ------------------------------------------------------------------
    // Saturating stall counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is software-visible state, so every entry is
            // reset explicitly rather than left as an uninitialised memory.
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_stall[c] && (cnt_q[c] != '1)) begin
                    cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt_out
        assign stall_cnt_o[c*CNT_W +: CNT_W] = cnt_q[c];
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with default parameters, plus a
// second instance with a 4-bit counter for the saturation case. Both
// instances share the same inputs.

module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  ch_req = '0;
    logic [1:0]  ch_hit = '0;
    logic [1:0]  ch_fill = '0;
    logic [1:0]  rd_valid = '0;
    logic [63:0] rd_pc = '0;
    logic        ack = 1'b0;

    logic [4:0]  hold, flush;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] cnt;

    logic [4:0]  hold_s, flush_s;
    logic        rv_s;
    logic [31:0] rpc_s;
    logic [7:0]  cnt_s;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ch_req_i         (ch_req),
        .ch_hit_i         (ch_hit),
        .ch_fill_ready_i  (ch_fill),
        .rd_valid_i       (rd_valid),
        .rd_pc_i          (rd_pc),
        .redirect_ack_i   (ack),
        .hold_o           (hold),
        .flush_o          (flush),
        .redirect_valid_o (rv),
        .redirect_pc_o    (rpc),
        .stall_cnt_o      (cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) u_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .ch_req_i         (ch_req),
        .ch_hit_i         (ch_hit),
        .ch_fill_ready_i  (ch_fill),
        .rd_valid_i       (rd_valid),
        .rd_pc_i          (rd_pc),
        .redirect_ack_i   (ack),
        .hold_o           (hold_s),
        .flush_o          (flush_s),
        .redirect_valid_o (rv_s),
        .redirect_pc_o    (rpc_s),
        .stall_cnt_o      (cnt_s)
    );

    typedef struct {
        int          grp;
        logic [1:0]  req;
        logic [1:0]  hit;
        logic [1:0]  fill;
        logic [1:0]  rdv;
        logic        ack;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [4:0]  exp_hold;
        logic [4:0]  exp_flush;
        logic        exp_rv;
        logic [31:0] exp_rpc;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input int g, input logic [1:0] req, input logic [1:0] hit,
                                input logic [1:0] fill, input logic [1:0] rdv, input logic a,
                                input logic [31:0] pc0, input logic [31:0] pc1,
                                input logic [4:0] eh, input logic [4:0] ef,
                                input logic erv, input logic [31:0] erpc);
        vec_t t;
        t.grp = g; t.req = req; t.hit = hit; t.fill = fill; t.rdv = rdv; t.ack = a;
        t.pc0 = pc0; t.pc1 = pc1;
        t.exp_hold = eh; t.exp_flush = ef; t.exp_rv = erv; t.exp_rpc = erpc;
        vecs.push_back(t);
    endfunction

    task automatic idle_inputs();
        ch_req = '0; ch_hit = '0; ch_fill = '0; rd_valid = '0; rd_pc = '0; ack = 1'b0;
    endtask

    // Advance one clock; leaves time at posedge + 1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Inputs are driven at posedge+1, outputs sampled at posedge+4.
    task automatic run_group(input int g);
        int cyc;
        cyc = 0;
        foreach (vecs[i]) begin
            if (vecs[i].grp == g) begin
                ch_req   = vecs[i].req;
                ch_hit   = vecs[i].hit;
                ch_fill  = vecs[i].fill;
                rd_valid = vecs[i].rdv;
                ack      = vecs[i].ack;
                rd_pc    = {vecs[i].pc1, vecs[i].pc0};
                #3;
                check($sformatf("g%0d c%0d hold", g, cyc),  64'(hold),  64'(vecs[i].exp_hold));
                check($sformatf("g%0d c%0d flush", g, cyc), 64'(flush), 64'(vecs[i].exp_flush));
                check($sformatf("g%0d c%0d rvalid", g, cyc), 64'(rv),   64'(vecs[i].exp_rv));
                check($sformatf("g%0d c%0d rpc", g, cyc),   64'(rpc),   64'(vecs[i].exp_rpc));
                tick();
                cyc++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---------------- vector table ----------------
        // g1: fetch miss on channel 0, fill rise at cycle 6
        add(1, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b00001, 5'b00010, 0, 0);
        for (int i = 1; i <= 5; i++)
            add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b00001, 5'b00010, 0, 0);
        add(1, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(1, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 0);
        // g2: data miss on channel 1, fill at cycle 4; then hits; idle fill edge
        add(2, 2'b10, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b01111, 5'b10000, 0, 0);
        for (int i = 1; i <= 3; i++)
            add(2, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b01111, 5'b10000, 0, 0);
        add(2, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(2, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(2, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(2, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 0);
        add(2, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 0);
        // g3: simultaneous redirects, source 1 (EX) wins; ack
        add(3, 2'b00, 2'b00, 2'b00, 2'b11, 0, 32'h100, 32'h200, 5'b00000, 5'b00111, 0, 0);
        add(3, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 5'b00001, 5'b00001, 1, 32'h200);
        add(3, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h200);
        // g4: overwrite of a pending redirect
        add(4, 2'b00, 2'b00, 2'b00, 2'b01, 0, 32'h40, 0, 5'b00000, 5'b00011, 0, 32'h200);
        add(4, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b00001, 5'b00001, 1, 32'h40);
        add(4, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0, 32'h80, 5'b00001, 5'b00111, 1, 32'h40);
        add(4, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 5'b00001, 5'b00001, 1, 32'h80);
        add(4, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h80);
        // g5: redirect blocked by a data stall, accepted when the fill releases it
        add(5, 2'b10, 2'b00, 2'b00, 2'b10, 0, 0, 32'h300, 5'b01111, 5'b10000, 0, 32'h80);
        add(5, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0, 32'h300, 5'b01111, 5'b10000, 0, 32'h80);
        add(5, 2'b00, 2'b00, 2'b10, 2'b10, 0, 0, 32'h300, 5'b00000, 5'b00111, 0, 32'h80);
        add(5, 2'b00, 2'b00, 2'b10, 2'b00, 1, 0, 0, 5'b00001, 5'b00001, 1, 32'h300);
        add(5, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h300);
        // g6: misses on both channels: union hold, bubble only below the deepest
        add(6, 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b01111, 5'b10000, 0, 32'h300);
        add(6, 2'b00, 2'b00, 2'b10, 2'b00, 0, 0, 0, 5'b00001, 5'b00010, 0, 32'h300);
        add(6, 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h300);
        add(6, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 5'b00000, 5'b00000, 0, 32'h300);

        // ---------------- reset state ----------------
        idle_inputs();
        #2;
        check("reset hold", 64'(hold), 64'h0);
        check("reset rvalid", 64'(rv), 64'h0);
        do_reset();
        check("post-reset hold", 64'(hold), 64'h0);
        check("post-reset flush", 64'(flush), 64'h0);
        check("post-reset rpc", 64'(rpc), 64'h0);
        check("post-reset cnt", 64'(cnt), 64'h0);

        // ---------------- table-driven groups ----------------
        run_group(1);
        check("fetch miss cnt0", 64'(cnt[15:0]), 64'd6);
        check("fetch miss cnt1", 64'(cnt[31:16]), 64'd0);
        run_group(2);
        check("data miss cnt1", 64'(cnt[31:16]), 64'd4);
        check("data miss cnt0", 64'(cnt[15:0]), 64'd6);
        run_group(3);
        run_group(4);
        run_group(5);
        check("blocked redirect cnt1", 64'(cnt[31:16]), 64'd6);
        run_group(6);
        check("dual miss cnt0", 64'(cnt[15:0]), 64'd8);
        check("dual miss cnt1", 64'(cnt[31:16]), 64'd7);

        // ---------------- reset in the middle of a miss ----------------
        do_reset();
        ch_req = 2'b01; ch_hit = 2'b00; rd_valid = 2'b10; rd_pc = {32'h500, 32'h0};
        #3;
        check("mid miss hold", 64'(hold), 64'b00001);
        check("mid miss flush", 64'(flush), 64'b00111);
        tick();
        idle_inputs();
        #1;
        check("mid miss pend hold", 64'(hold), 64'b00001);
        check("mid miss pend flush", 64'(flush), 64'b00011);
        check("mid miss rvalid", 64'(rv), 64'h1);
        check("mid miss rpc", 64'(rpc), 64'h500);
        ch_req = 2'b01; ch_hit = 2'b00;
        rst_n = 1'b0;
        #1;
        check("in reset hold", 64'(hold), 64'h0);
        check("in reset flush", 64'(flush), 64'h0);
        check("in reset rvalid", 64'(rv), 64'h0);
        check("in reset rpc", 64'(rpc), 64'h0);
        check("in reset cnt", 64'(cnt), 64'h0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #2;
        check("after reset fsm idle hold", 64'(hold), 64'h0);
        check("after reset fsm idle flush", 64'(flush), 64'h0);

        // ---------------- 20-cycle stall, 4-bit counter saturates ----------------
        do_reset();
        ch_req = 2'b01; ch_hit = 2'b00;
        tick();
        idle_inputs();
        repeat (19) tick();
        #2;
        check("long stall hold", 64'(hold_s), 64'b00001);
        check("sat cnt0 during", 64'(cnt_s[3:0]), 64'd15);
        ch_fill = 2'b01;
        #1;
        check("long stall release", 64'(hold_s), 64'h0);
        tick();
        check("wide cnt0", 64'(cnt[15:0]), 64'd20);
        check("sat cnt0", 64'(cnt_s[3:0]), 64'd15);
        check("sat cnt1", 64'(cnt_s[7:4]), 64'd0);
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
